// File: rtl/adc_iq_rx.sv
// Interleaved two-channel ADC receiver: locks onto the A/B tag toggle and emits paired samples.
// Optional overrange flag (ovr_clr / ovr_flag) is built when ADC_RX_OVR_EN is defined.
module adc_iq_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] adc_data,
  input  logic        adc_sel,
  input  logic        enable,
`ifdef ADC_RX_OVR_EN
  input  logic        ovr_clr,
  output logic        ovr_flag,
`endif
  output logic [13:0] data_out_A,
  output logic [13:0] data_out_B,
  output logic        data_valid,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_t;

  state_t      state_q, state_d;

  logic [13:0] d_r_q;
  logic        s_r_q;
  logic        s_p_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        a_held_q, a_held_d;
  logic [13:0] hold_a_q, hold_a_d;
  logic [13:0] out_a_q, out_a_d;
  logic [13:0] out_b_q, out_b_d;
  logic        dv_q, dv_d;
  logic        serr_q, serr_d;
  logic        locked_q, locked_d;
  logic        toggle;

  assign toggle = (s_r_q != s_p_q);

  // Input stage: every decision is made on the registered word and tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_r_q <= '0;
      s_r_q <= 1'b0;
      s_p_q <= 1'b0;
    end else begin
      d_r_q <= adc_data;
      s_r_q <= adc_sel;
      s_p_q <= s_r_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SEARCH;
        SEARCH:  if (toggle && (cnt_q == 3'd7)) state_d = LOCKED;
        LOCKED:  if (!toggle) state_d = SEARCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    a_held_d = a_held_q;
    hold_a_d = hold_a_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    dv_d     = 1'b0;
    serr_d   = 1'b0;
    if (!enable) begin
      cnt_d    = '0;
      a_held_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d    = '0;
          a_held_d = 1'b0;
        end
        SEARCH: begin
          // Wraps 7 -> 0 on the locking toggle, so the counter is clear in LOCKED.
          cnt_d    = toggle ? cnt_q + 3'd1 : 3'd0;
          a_held_d = 1'b0;
        end
        LOCKED: begin
          if (!toggle) begin
            serr_d   = 1'b1;
            a_held_d = 1'b0;
            cnt_d    = '0;
          end else if (!s_r_q) begin
            hold_a_d = d_r_q;
            a_held_d = 1'b1;
          end else if (a_held_q) begin
            out_a_d  = hold_a_q;
            out_b_d  = d_r_q;
            dv_d     = 1'b1;
            a_held_d = 1'b0;
          end
        end
        default: begin
          cnt_d    = '0;
          a_held_d = 1'b0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      a_held_q <= 1'b0;
      hold_a_q <= '0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      dv_q     <= 1'b0;
      serr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      a_held_q <= a_held_d;
      hold_a_q <= hold_a_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      dv_q     <= dv_d;
      serr_q   <= serr_d;
      locked_q <= locked_d;
    end
  end

  assign data_out_A = out_a_q;
  assign data_out_B = out_b_q;
  assign data_valid = dv_q;
  assign locked     = locked_q;
  assign sync_err   = serr_q;

`ifdef ADC_RX_OVR_EN
  logic ovr_flag_q, ovr_flag_d;
  logic ovr_hit;

  function automatic logic is_rail(input logic [13:0] v);
    return (v == 14'h0000) || (v == 14'h3FFF);
  endfunction

  assign ovr_hit = dv_d && (is_rail(hold_a_q) || is_rail(d_r_q));

  // Set has priority over a coincident clear.
  always_comb begin
    ovr_flag_d = ovr_hit | (ovr_flag_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_flag_q <= 1'b0;
    end else begin
      ovr_flag_q <= ovr_flag_d;
    end
  end

  assign ovr_flag = ovr_flag_q;
`endif

endmodule

// File: tb/tb_adc_iq_rx.sv
// Directed bench for adc_iq_rx: scoreboard of expected A/B pairs keyed by the output cycle.
module tb_adc_iq_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] adc_data = '0;
  logic        adc_sel = 1'b0;
  logic        enable = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [13:0] data_out_A;
  logic [13:0] data_out_B;
  logic        data_valid;
  logic        locked;
  logic        sync_err;
`ifdef ADC_RX_OVR_EN
  logic        ovr_flag;
`endif

  adc_iq_rx dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_sel    (adc_sel),
    .enable     (enable),
`ifdef ADC_RX_OVR_EN
    .ovr_clr    (ovr_clr),
    .ovr_flag   (ovr_flag),
`endif
    .data_out_A (data_out_A),
    .data_out_B (data_out_B),
    .data_valid (data_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    int unsigned cyc;
  } pair_t;

  pair_t       sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  logic        exp_serr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [13:0] a, input logic [13:0] b);
    pair_t p;
    p.a = a;
    p.b = b;
    p.cyc = cyc + 1;
    sb.push_back(p);
  endtask

  // One bus word per clock; outputs are checked 1 time unit after the edge.
  task automatic step(input logic en, input logic sel, input logic [13:0] d);
    pair_t p;
    logic  exp_dv;
    enable   = en;
    adc_sel  = sel;
    adc_data = d;
    @(posedge clk);
    #1;
    cyc++;
    exp_dv = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("data_valid", data_valid, exp_dv);
    chk("sync_err", sync_err, exp_serr);
    if (exp_dv) begin
      p = sb.pop_front();
      chk("data_out_A", data_out_A, p.a);
      chk("data_out_B", data_out_B, p.b);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_A"}, data_out_A, 0);
    chk({tag, "_B"}, data_out_B, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_serr"}, sync_err, 0);
`ifdef ADC_RX_OVR_EN
    chk({tag, "_ovr"}, ovr_flag, 0);
`endif
  endtask

  initial begin
    logic [13:0] a;
    logic [13:0] b;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // First enabled edge enters SEARCH; the next compares against reset tags,
    // then 8 toggles lock on the 10th word.
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, (i % 2) == 0, 14'(32'h0100 + i));
      chk("lock1", locked, i == 10);
    end

    // First LOCKED word (0x010A, a B) is dropped; next A pairs with following B.
    step(1'b1, 1'b0, 14'h1234);
    step(1'b1, 1'b1, 14'h0ABC);
    push(14'h1234, 14'h0ABC);

    for (int k = 0; k < 4; k++) begin
      a = 14'($urandom_range(1, 16382));
      b = 14'($urandom_range(1, 16382));
      step(1'b1, 1'b0, a);
      step(1'b1, 1'b1, b);
      push(a, b);
    end
`ifdef ADC_RX_OVR_EN
    chk("ovr_idle", ovr_flag, 0);
`endif

    // Repeated B tag breaks interleave; relock needs 8 further toggles.
    step(1'b1, 1'b1, 14'h0DDD);
    for (int i = 0; i <= 8; i++) begin
      exp_serr = (i == 0);
      step(1'b1, (i % 2) == 1, (i == 8) ? 14'h2AAA : 14'(32'h0300 + i));
      chk("relock", locked, i == 8);
    end
    exp_serr = 1'b0;

    // Reset between A (0x2AAA) and its B.
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_assert");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b1;

    // Starting on a B tag, the reset tag value counts as the first toggle: lock on word 9.
    for (int j = 1; j <= 9; j++) begin
      step(1'b1, (j % 2) == 1, 14'(32'h0200 + j));
      chk("lock2", locked, j == 9);
    end

    step(1'b1, 1'b0, 14'h3FFF);
    step(1'b1, 1'b1, 14'h0100);
    push(14'h3FFF, 14'h0100);
    step(1'b1, 1'b0, 14'h0055);
`ifdef ADC_RX_OVR_EN
    chk("ovr_set", ovr_flag, 1);
`endif
    ovr_clr = 1'b1;
    step(1'b1, 1'b1, 14'h0066);
    push(14'h0055, 14'h0066);
    ovr_clr = 1'b0;
`ifdef ADC_RX_OVR_EN
    chk("ovr_clr", ovr_flag, 0);
`endif
    step(1'b1, 1'b0, 14'h0000);
`ifdef ADC_RX_OVR_EN
    chk("ovr_normal_pair", ovr_flag, 0);
`endif
    step(1'b1, 1'b1, 14'h0123);
    push(14'h0000, 14'h0123);
    ovr_clr = 1'b1;
    step(1'b1, 1'b0, 14'h0777);
    ovr_clr = 1'b0;
`ifdef ADC_RX_OVR_EN
    chk("ovr_set_wins", ovr_flag, 1);
`endif
    step(1'b1, 1'b1, 14'h0888);
    push(14'h0777, 14'h0888);
    step(1'b1, 1'b0, 14'h0001);

    // Dropping enable forces IDLE and holds the last pair.
    step(1'b0, 1'b1, 14'h0002);
    chk("en_off_locked", locked, 0);
    chk("en_off_hold_A", data_out_A, 14'h0777);
    chk("en_off_hold_B", data_out_B, 14'h0888);
    step(1'b0, 1'b0, 14'h0003);
    chk("en_off_locked2", locked, 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
